// File: rtl/bubble_drive8_top.sv
// Bubble-memory loop emulator: streams a boot image or a replicated page as
// odd/even loop bit pairs, one pair per bubble bit period.
module bubble_drive8_top #(
    parameter int BIT_PERIOD = 1000,
    parameter int LOOP_LEN   = 2053,
    parameter int REP_DELAY  = 16
) (
    input  logic       master_clock,
    input  logic       power_good,
    input  logic       bubble_shift_enable,
    input  logic       replicator_enable,
    input  logic       bootloop_enable,
    input  logic [2:0] image_dip_switch,
    output logic       clock_out,
    output logic       bubble_out_odd,
    output logic       bubble_out_even
);
    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int PW = (LOOP_LEN > 1) ? $clog2(LOOP_LEN) : 1;
    localparam int DW = (REP_DELAY > 0) ? $clog2(REP_DELAY + 1) : 1;
    // Active-low enables come out of reset deasserted so nothing shifts early.
    localparam logic [5:0] SYNC_RST = 6'b110000;

    logic [5:0] raw, sync1_reg, sync2_reg;
    logic       shift_s, rep_s, boot_s;
    logic [2:0] img_s;

    logic [CW-1:0] bit_cnt_reg, bit_cnt_next;
    logic [PW-1:0] pos_reg, pos_next;
    logic [7:0]    p_reg, p_next;
    logic [7:0]    boot_idx_reg, boot_idx_next;
    logic          win_active_reg, win_active_next;
    logic [DW-1:0] win_delay_reg, win_delay_next;
    logic [7:0]    win_idx_reg, win_idx_next;
    logic          shift_prev_reg, rep_prev_reg, boot_prev_reg;
    logic          clk_reg, clk_next;
    logic          odd_reg, odd_next, even_reg, even_next;

    logic       boundary, shift_on, shift_fall, rep_rise, mode_chg;
    logic [7:0] boot_eff;
    logic [1:0] pair;

    assign raw = {bubble_shift_enable, replicator_enable, bootloop_enable, image_dip_switch};
    assign {shift_s, rep_s, boot_s, img_s} = sync2_reg;

    function automatic logic [7:0] data_byte(input logic [7:0] base, input logic [5:0] k,
                                             input logic [2:0] img);
        return base ^ {2'b00, k} ^ {img, 5'b0};
    endfunction

    // Pair n of a byte holds stream bits 2n (odd) and 2n+1 (even), MSB first.
    function automatic logic [1:0] pair_bits(input logic [7:0] data, input logic [1:0] sel);
        logic [7:0] sh;
        sh = data << {sel, 1'b0};
        return sh[7:6];
    endfunction

    assign boundary   = (bit_cnt_reg == '0);
    assign shift_on   = ~shift_s;
    assign shift_fall = shift_prev_reg & ~shift_s;
    assign rep_rise   = ~rep_prev_reg & rep_s & boot_s;
    assign mode_chg   = (boot_s != boot_prev_reg);
    assign boot_eff   = shift_fall ? 8'd0 : boot_idx_reg;

    always_comb begin
        bit_cnt_next    = (bit_cnt_reg == CW'(BIT_PERIOD - 1)) ? '0 : bit_cnt_reg + CW'(1);
        clk_next        = (bit_cnt_reg < CW'(BIT_PERIOD / 2));
        pos_next        = pos_reg;
        p_next          = p_reg;
        boot_idx_next   = boot_eff;
        win_active_next = win_active_reg;
        win_delay_next  = win_delay_reg;
        win_idx_next    = win_idx_reg;
        odd_next        = odd_reg;
        even_next       = even_reg;
        pair            = 2'b00;

        if (mode_chg)
            win_active_next = 1'b0;

        if (rep_rise) begin
            p_next          = 8'(pos_reg);
            win_active_next = 1'b1;
            win_delay_next  = DW'(REP_DELAY);
            win_idx_next    = 8'd0;
        end

        if (boundary) begin
            if (shift_on) begin
                pos_next = (pos_reg == PW'(LOOP_LEN - 1)) ? '0 : pos_reg + PW'(1);
                if (!boot_s) begin
                    pair          = pair_bits(data_byte(8'hA5, boot_eff[7:2], img_s), boot_eff[1:0]);
                    boot_idx_next = boot_eff + 8'd1;
                end else if (win_active_reg && !mode_chg && !rep_rise) begin
                    if (win_delay_reg != '0) begin
                        win_delay_next = win_delay_reg - DW'(1);
                    end else begin
                        pair         = pair_bits(data_byte(p_reg, win_idx_reg[7:2], img_s), win_idx_reg[1:0]);
                        win_idx_next = win_idx_reg + 8'd1;
                        if (win_idx_reg == 8'hFF)
                            win_active_next = 1'b0;
                    end
                end
            end
            odd_next  = pair[1];
            even_next = pair[0];
        end
    end

    always_ff @(posedge master_clock or posedge power_good) begin
        if (power_good) begin
            sync1_reg      <= SYNC_RST;
            sync2_reg      <= SYNC_RST;
            bit_cnt_reg    <= '0;
            pos_reg        <= '0;
            p_reg          <= 8'd0;
            boot_idx_reg   <= 8'd0;
            win_active_reg <= 1'b0;
            win_delay_reg  <= '0;
            win_idx_reg    <= 8'd0;
            shift_prev_reg <= 1'b1;
            rep_prev_reg   <= 1'b1;
            boot_prev_reg  <= 1'b0;
            clk_reg        <= 1'b0;
            odd_reg        <= 1'b0;
            even_reg       <= 1'b0;
        end else begin
            sync1_reg      <= raw;
            sync2_reg      <= sync1_reg;
            bit_cnt_reg    <= bit_cnt_next;
            pos_reg        <= pos_next;
            p_reg          <= p_next;
            boot_idx_reg   <= boot_idx_next;
            win_active_reg <= win_active_next;
            win_delay_reg  <= win_delay_next;
            win_idx_reg    <= win_idx_next;
            shift_prev_reg <= shift_s;
            rep_prev_reg   <= rep_s;
            boot_prev_reg  <= boot_s;
            clk_reg        <= clk_next;
            odd_reg        <= odd_next;
            even_reg       <= even_next;
        end
    end

    assign clock_out       = clk_reg;
    assign bubble_out_odd  = odd_reg;
    assign bubble_out_even = even_reg;
endmodule

// File: tb/tb_bubble_drive8_top.sv
// Bench for bubble_drive8_top: directed tables and sequences plus random
// stimulus, all checked against a bit-period-level stream model.
module tb_bubble_drive8_top;
    localparam int BP = 16;
    localparam int LL = 53;
    localparam int RD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       shift_n = 1'b1;
    logic       rep_n = 1'b1;
    logic       boot = 1'b1;
    logic [2:0] img = 3'd0;
    logic       clock_out, odd, even;

    bubble_drive8_top #(.BIT_PERIOD(BP), .LOOP_LEN(LL), .REP_DELAY(RD)) dut (
        .master_clock(clk),
        .power_good(rst),
        .bubble_shift_enable(shift_n),
        .replicator_enable(rep_n),
        .bootloop_enable(boot),
        .image_dip_switch(img),
        .clock_out(clock_out),
        .bubble_out_odd(odd),
        .bubble_out_even(even)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: loop position, boot pair index, latched page and the
    // pending window as a queue of pair indices (-1 = delay slot).
    int pos, bidx, p_lat;
    int win_q[$];
    bit prev_shift, prev_boot;

    typedef struct {
        bit         sh;
        bit         bt;
        logic [2:0] iv;
        logic [1:0] exp;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_pair(input bit page, input int n, input int p, input int i);
        int         v, b0;
        logic [7:0] by;
        v  = (page ? (p % 256) : 'hA5) ^ (n / 4) ^ (i * 32);
        by = v[7:0];
        b0 = 7 - ((2 * n) % 8);
        return {by[b0], by[b0-1]};
    endfunction

    // Called between edges; leaves time just after the first boundary edge.
    task automatic do_reset();
        rst = 1'b1;
        shift_n = 1'b1;
        rep_n = 1'b1;
        #2;
        check("rst_out", {clock_out, odd, even}, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_boundary", {clock_out, odd, even}, 3'b100);
        pos = 0;
        bidx = 0;
        win_q.delete();
        prev_shift = 1'b0;
        prev_boot = boot;
    endtask

    // One bit period: drive inputs just after a boundary, run to the next
    // boundary and compare the new pair with the model.
    task automatic step(input bit sh, input bit rp, input bit bt, input logic [2:0] iv,
                        output logic [1:0] act);
        logic [1:0] exp, held;
        int         highs, e;
        check("clk_phase", clock_out, 1'b1);
        shift_n = ~sh;
        boot = bt;
        img = iv;
        rep_n = rp ? 1'b0 : 1'b1;
        held = {odd, even};
        highs = 0;
        for (int c = 0; c < BP; c++) begin
            if (clock_out) highs++;
            if (c == BP / 2) check("hold", {odd, even}, held);
            @(posedge clk);
            #1;
            if (c == 2) rep_n = 1'b1;
        end
        if (rp && bt && prev_boot) begin
            p_lat = pos;
            win_q.delete();
            repeat (RD) win_q.push_back(-1);
            for (int n = 0; n < 256; n++) win_q.push_back(n);
        end
        if (bt != prev_boot) win_q.delete();
        if (sh && !prev_shift) bidx = 0;
        exp = 2'b00;
        if (sh) begin
            if (!bt) begin
                exp = ref_pair(1'b0, bidx, 0, int'(iv));
                bidx = (bidx + 1) % 256;
            end else if (win_q.size() > 0) begin
                e = win_q.pop_front();
                if (e >= 0) exp = ref_pair(1'b1, e, p_lat, int'(iv));
            end
            pos = (pos + 1) % LL;
        end
        prev_shift = sh;
        prev_boot = bt;
        act = {odd, even};
        check("pair", act, exp);
        check("clk_high", highs, BP / 2);
    endtask

    task automatic collect_byte(input bit bt, input logic [2:0] iv, output logic [7:0] by);
        logic [1:0] a;
        by = 8'd0;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, bt, iv, a);
            by = {by[5:0], a};
        end
    endtask

    initial begin
        logic [1:0] act;
        logic [7:0] by;
        bit         bt_r, flip, rp_r;
        logic [2:0] iv_r;

        // Boot image I=7: bytes 0x45, 0x44; a new shift-enable fall restarts at pair 0.
        tbl[0]  = '{1'b1, 1'b0, 3'd7, 2'b01};
        tbl[1]  = '{1'b1, 1'b0, 3'd7, 2'b00};
        tbl[2]  = '{1'b1, 1'b0, 3'd7, 2'b01};
        tbl[3]  = '{1'b1, 1'b0, 3'd7, 2'b01};
        tbl[4]  = '{1'b1, 1'b0, 3'd7, 2'b01};
        tbl[5]  = '{1'b1, 1'b0, 3'd7, 2'b00};
        tbl[6]  = '{1'b1, 1'b0, 3'd7, 2'b01};
        tbl[7]  = '{1'b1, 1'b0, 3'd7, 2'b00};
        tbl[8]  = '{1'b0, 1'b0, 3'd7, 2'b00};
        tbl[9]  = '{1'b1, 1'b0, 3'd7, 2'b01};
        tbl[10] = '{1'b1, 1'b0, 3'd7, 2'b00};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 2'b01};

        #3;
        boot = 1'b1;
        do_reset();

        // Idle with shift disabled: clock keeps running, outputs stay quiet.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 3'd0, act);
            check("idle_out", act, 2'b00);
        end

        boot = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].sh, 1'b0, tbl[i].bt, tbl[i].iv, act);
            check($sformatf("tbl%0d", i), act, tbl[i].exp);
        end
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0, 3'd7, act);

        // Page replicate at position 0x10, I=7.
        boot = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 3'd7, act);
        step(1'b0, 1'b1, 1'b1, 3'd7, act);
        for (int i = 0; i < RD; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd7, act);
            check("rep_delay", act, 2'b00);
        end
        collect_byte(1'b1, 3'd7, by);
        check("page_byte0", by, 8'hF0);
        collect_byte(1'b1, 3'd7, by);
        check("page_byte1", by, 8'hF1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 3'd7, act);
            check("paused", act, 2'b00);
        end
        collect_byte(1'b1, 3'd7, by);
        check("page_resume", by, 8'hF2);
        for (int i = 12; i < 256; i++) step(1'b1, 1'b0, 1'b1, 3'd7, act);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd7, act);
            check("after_window", act, 2'b00);
        end

        // Reset mid-window aborts output at once and nothing resumes.
        step(1'b1, 1'b1, 1'b1, 3'd7, act);
        for (int i = 0; i < RD + 6; i++) step(1'b1, 1'b0, 1'b1, 3'd7, act);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd7, act);
            check("post_reset", act, 2'b00);
        end

        // Full loop wrap: replicate after LL shifts must see position 0.
        do_reset();
        for (int i = 0; i < LL; i++) step(1'b1, 1'b0, 1'b1, 3'd2, act);
        step(1'b0, 1'b1, 1'b1, 3'd2, act);
        for (int i = 0; i < RD; i++) step(1'b1, 1'b0, 1'b1, 3'd2, act);
        collect_byte(1'b1, 3'd2, by);
        check("wrap_byte", by, 8'h40);

        // Random traffic against the model.
        do_reset();
        bt_r = 1'b1;
        iv_r = 3'($urandom_range(0, 7));
        for (int i = 0; i < 1200; i++) begin
            flip = ($urandom_range(0, 99) == 0);
            if (flip) bt_r = ~bt_r;
            rp_r = !flip && bt_r && ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) iv_r = 3'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 8, rp_r, bt_r, iv_r, act);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
